// File: rtl/alu_result_stage.sv
// Result stage behind the saturating adder: 2-entry skid buffer with valid/ready on both sides,
// condition flags computed at capture and committed to the architectural FLAGS register on retire.
module alu_result_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_sum,
  input  logic         i_cout,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  input  logic         i_sub,
  input  logic [2:0]   i_flag_en,
  input  logic         i_flush,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_result,
  output logic         o_out_cout,
  output logic [2:0]   o_flags
);

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic [2:0]   flg;   // {Z,V,N}
    logic [2:0]   en;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  // Signed overflow of the unsaturated add/sub; the adder saturates exactly when this is set.
  function automatic logic calc_v(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] raw;
    logic       eb;
    eb  = b[W-1] ^ sub;
    raw = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    return (a[W-1] == eb) && (raw[W-1] != a[W-1]);
  endfunction

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_in_entry;
  logic   [2:0] r_flags;
  logic   w_acc;
  logic   w_pop;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid;

  assign w_in_entry.result = i_sum;
  assign w_in_entry.cout   = i_cout;
  assign w_in_entry.flg    = {(i_sum == {W{1'b0}}), calc_v(i_op_a, i_op_b, i_sub), i_sum[W-1]};
  assign w_in_entry.en     = i_flag_en;

  assign o_in_ready   = (r_state != ST_FULL);
  assign o_out_valid  = (r_state != ST_EMPTY);
  assign o_out_result = r_main.result;
  assign o_out_cout   = r_main.cout;
  assign o_flags      = r_flags;

  assign w_acc = i_in_valid && (r_state != ST_FULL);
  assign w_pop = (r_state != ST_EMPTY) && i_out_ready;

  // Next-state and buffer load selection; flush overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Buffer occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main entry drives the outputs and keeps its contents while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= {$bits(entry_t){1'b0}};
    end else if (w_ld_main_in) begin
      r_main <= w_in_entry;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
  end

  // Skid entry absorbs the one input accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= {$bits(entry_t){1'b0}};
    end else if (w_ld_skid) begin
      r_skid <= w_in_entry;
    end
  end

  // Flags retire with the entry, even in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else if (w_pop) begin
      r_flags <= (r_main.flg & r_main.en) | (r_flags & ~r_main.en);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios then randomized traffic,
// checked against a queue model using plain signed arithmetic for the flags.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [15:0] i_sum = 16'h0;
  logic        i_cout = 1'b0;
  logic [15:0] i_op_a = 16'h0;
  logic [15:0] i_op_b = 16'h0;
  logic        i_sub = 1'b0;
  logic [2:0]  i_flag_en = 3'b000;
  logic        i_flush = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_out_result;
  logic        o_out_cout;
  logic [2:0]  o_flags;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic [2:0]  f;
    logic [2:0]  en;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] m_flags = 3'b000;
  int         n_tests = 0;
  int         n_fail = 0;

  alu_result_stage #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_sum(i_sum), .i_cout(i_cout), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_sub(i_sub),
    .i_flag_en(i_flag_en), .i_flush(i_flush), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_result(o_out_result), .o_out_cout(o_out_cout),
    .o_flags(o_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int true_result(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return s ? (sa - sb) : (sa + sb);
  endfunction

  function automatic logic [15:0] saturate(input int t);
    if (t > 32767) return 16'h7FFF;
    if (t < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic [15:0] a, input logic [15:0] b,
                              input logic sb, input logic c, input logic [2:0] en);
    exp_t e;
    int   t;
    t     = true_result(a, b, sb);
    e.res = s;
    e.cout = c;
    e.f   = {(s == 16'h0000), ((t > 32767) || (t < -32768)), s[15]};
    e.en  = en;
    return e;
  endfunction

  // Monitor/scoreboard: check outputs mid-cycle, then predict the coming rising edge.
  always @(negedge clk) begin : scoreboard
    int   sz;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_flags = 3'b000;
    end else begin
      sz = exp_q.size();
      chk("flags", o_flags, m_flags);
      chk("out_valid", o_out_valid, sz > 0);
      chk("in_ready", o_in_ready, sz < 2);
      if (sz > 0) begin
        chk("out_result", o_out_result, exp_q[0].res);
        chk("out_cout", o_out_cout, exp_q[0].cout);
      end
      if (i_out_ready && sz > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) if (e.en[i]) m_flags[i] = e.f[i];
      end
      if (i_flush) exp_q.delete();
      else if (i_in_valid && sz < 2) exp_q.push_back(mk(i_sum, i_op_a, i_op_b, i_sub, i_cout, i_flag_en));
    end
  end

  task automatic put(input logic v, input logic [15:0] s, input logic [15:0] a, input logic [15:0] b,
                     input logic sb, input logic [2:0] en, input logic rdy, input logic fl);
    i_in_valid = v; i_sum = s; i_op_a = a; i_op_b = b; i_sub = sb;
    i_flag_en = en; i_out_ready = rdy; i_flush = fl; i_cout = s[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) put(1'b0, 16'h1234, 16'h0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        sb;
    #3;
    chk("rst_out_valid", o_out_valid, 1'b0);
    chk("rst_in_ready", o_in_ready, 1'b1);
    chk("rst_result", o_out_result, 16'h0);
    chk("rst_cout", o_out_cout, 1'b0);
    chk("rst_flags", o_flags, 3'b000);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1..3: flag derivation
    put(1'b1, 16'h0005, 16'h0002, 16'h0003, 1'b0, 3'b111, 1'b1, 1'b0);
    chk("t1_out_valid", o_out_valid, 1'b1);
    chk("t1_result", o_out_result, 16'h0005);
    idle(2);
    chk("t1_flags", o_flags, 3'b000);
    put(1'b1, 16'h7FFF, 16'h7FFF, 16'h0001, 1'b0, 3'b111, 1'b1, 1'b0);
    idle(2);
    chk("t2_flags", o_flags, 3'b010);
    put(1'b1, 16'h8000, 16'h8000, 16'h0001, 1'b1, 3'b111, 1'b1, 1'b0);
    idle(2);
    chk("t3_flags_vn", o_flags, 3'b011);
    put(1'b1, 16'h0000, 16'h0005, 16'h0005, 1'b1, 3'b111, 1'b1, 1'b0);
    idle(2);
    chk("t3_flags_z", o_flags, 3'b100);

    // 4: back-pressure, third input waits for in_ready
    put(1'b1, 16'h0011, 16'h0010, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0);
    put(1'b1, 16'h0022, 16'h0020, 16'h0002, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("t4_in_ready_full", o_in_ready, 1'b0);
    put(1'b1, 16'h0033, 16'h0030, 16'h0003, 1'b0, 3'b000, 1'b0, 1'b0);
    put(1'b1, 16'h0033, 16'h0030, 16'h0003, 1'b0, 3'b000, 1'b1, 1'b0);
    chk("t4_second", o_out_result, 16'h0022);
    put(1'b1, 16'h0033, 16'h0030, 16'h0003, 1'b0, 3'b000, 1'b1, 1'b0);
    chk("t4_third", o_out_result, 16'h0033);
    idle(3);

    // 5: flush while full with a competing input
    put(1'b1, 16'h0044, 16'h0040, 16'h0004, 1'b0, 3'b111, 1'b0, 1'b0);
    put(1'b1, 16'h0055, 16'h0050, 16'h0005, 1'b0, 3'b111, 1'b0, 1'b0);
    put(1'b1, 16'h0066, 16'h0060, 16'h0006, 1'b0, 3'b111, 1'b0, 1'b1);
    chk("t5_out_valid", o_out_valid, 1'b0);
    chk("t5_in_ready", o_in_ready, 1'b1);
    chk("t5_flags", o_flags, 3'b100);
    idle(3);

    // 6: partial flag enable, then asynchronous reset mid-stream
    put(1'b1, 16'h8000, 16'h8000, 16'h0001, 1'b1, 3'b111, 1'b1, 1'b0);
    idle(2);
    put(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b001, 1'b1, 1'b0);
    idle(2);
    chk("t6_flags_n_only", o_flags, 3'b010);
    put(1'b1, 16'h0077, 16'h0070, 16'h0007, 1'b0, 3'b111, 1'b0, 1'b0);
    put(1'b1, 16'h0088, 16'h0080, 16'h0008, 1'b0, 3'b111, 1'b0, 1'b0);
    i_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", o_out_valid, 1'b0);
    chk("t6_rst_in_ready", o_in_ready, 1'b1);
    chk("t6_rst_result", o_out_result, 16'h0);
    chk("t6_rst_cout", o_out_cout, 1'b0);
    chk("t6_rst_flags", o_flags, 3'b000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 16'h7FF0 + 16'($urandom_range(0, 31)) : 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'h8000 + 16'($urandom_range(0, 15)) : 16'($urandom);
      sb = 1'($urandom);
      s  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : saturate(true_result(a, b, sb));
      put(1'($urandom_range(0, 9) < 7), s, a, b, sb, 3'($urandom), 1'($urandom_range(0, 9) < 6),
          $urandom_range(0, 99) < 3);
    end
    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
